// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Operation codes as presented on the op input, and the control FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle unsigned multiply (shift-add) / restoring divide datapath.
// Latency: WIDTH step cycles after load; last_o marks the final step.
// No backpressure: the controller issues load/step and reads hi_o/lo_o.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  // hi holds the product upper half (multiply) or the partial remainder (divide);
  // lo holds the multiplier being consumed LSB-first, or the dividend/quotient shift register.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Single iteration: conditional add-and-shift-right, or shift-left-and-trial-subtract.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Load operands on accept, then advance one iteration per step cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      cnt_q <= '0;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO register pair with iterative MULT/MULTU/DIV/DIVU and direct HI/LO writes.
// Latency: result committed WIDTH+1 cycles after start is accepted; done pulses the cycle after.
// Backpressure: busy high while in flight; start and direct writes are dropped while busy.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] in_data_hi,
  input  logic [WIDTH-1:0] in_data_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_hi,
  output logic [WIDTH-1:0] data_lo
);

  state_t state_q, state_d;
  logic   accept;
  logic   done_q, done_d;

  logic             op_signed, op_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic             is_div_q, is_signed_q, neg_a_q, neg_b_q, div0_q;
  logic [WIDTH-1:0] raw_a_q;

  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   core_hi, core_lo;
  logic               core_last;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign a_mag     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // Control FSM next state; done is raised for the cycle after the FIX commit.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and done pulse registers; reset aborts any operation without a done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Capture what the FIX step needs: op class, operand signs, divide-by-zero, raw dividend.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      div0_q      <= 1'b0;
      raw_a_q     <= '0;
    end else if (accept) begin
      is_div_q    <= op_div;
      is_signed_q <= op_signed;
      neg_a_q     <= src_a[WIDTH-1];
      neg_b_q     <= src_b[WIDTH-1];
      div0_q      <= op_div && (src_b == '0);
      raw_a_q     <= src_a;
    end
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (accept),
    .step_i   (state_q == ST_RUN),
    .is_div_i (is_div_q),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .hi_o     (core_hi),
    .lo_o     (core_lo),
    .last_o   (core_last)
  );

  // Sign correction of the magnitude result; remainder follows the dividend sign.
  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = (is_signed_q && (neg_a_q ^ neg_b_q)) ? -prod : prod;
    quo_fix  = (is_signed_q && (neg_a_q ^ neg_b_q)) ? -core_lo : core_lo;
    rem_fix  = (is_signed_q && neg_a_q) ? -core_hi : core_hi;
  end

  // HI/LO next value: commit at FIX, direct writes only while idle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == ST_FIX) begin
      if (div0_q) begin
        hi_d = raw_a_q;
        lo_d = '1;
      end else if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end else if (state_q == ST_IDLE) begin
      if (write_hi) hi_d = in_data_hi;
      if (write_lo) lo_d = in_data_lo;
    end
  end

  // HI/LO storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign data_hi = hi_q;
  assign data_lo = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo at WIDTH = 32.
// Directed cases plus randomized back-to-back operations against a plain-arithmetic model.
module tb_muldiv_hilo;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        write_hi, write_lo;
  logic [31:0] in_data_hi, in_data_lo;
  logic        busy, done;
  logic [31:0] data_hi, data_lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mh, ml;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .write_hi   (write_hi),
    .write_lo   (write_lo),
    .in_data_hi (in_data_hi),
    .in_data_lo (in_data_lo),
    .busy       (busy),
    .done       (done),
    .data_hi    (data_hi),
    .data_lo    (data_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from the architectural definition using 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, r;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'd0: r = 64'(sa * sb);
      2'd1: r = ua * ub;
      2'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq = a / b;
          ur = a % b;
          r  = {ur, uq};
        end
      end
    endcase
    return r;
  endfunction

  // Called at a negedge. Issues one operation, checks timing and result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inj_start, input bit inj_wr);
    logic [63:0] exp;
    logic [31:0] hb, lb;
    int          k;
    int          busy_cnt;
    bit          seen2;
    exp      = model(o, a, b);
    hb       = data_hi;
    lb       = data_lo;
    busy_cnt = 0;
    start    = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 60; k++) begin
      start    = inj_start && (k == 4);
      if (start) begin
        op    = 2'd1;
        src_a = 32'd5;
        src_b = 32'd5;
      end
      write_hi   = inj_wr && (k == 8);
      in_data_hi = 32'hDEAD_BEEF;
      if (done) break;
      busy_cnt += int'(busy);
      chk("hilo_stable_while_busy", {data_hi, data_lo}, {hb, lb});
      @(negedge clk);
    end
    start    = 1'b0;
    write_hi = 1'b0;
    chk("done_edge", 64'(k), 64'd33);
    chk("busy_cycles", 64'(busy_cnt), 64'd33);
    chk("busy_low_at_done", 64'(busy), 64'd0);
    chk("result_hi", 64'(data_hi), 64'(exp[63:32]));
    chk("result_lo", 64'(data_lo), 64'(exp[31:0]));
    mh = exp[63:32];
    ml = exp[31:0];
    if (inj_start) begin
      seen2 = 1'b0;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (done) seen2 = 1'b1;
      end
      chk("no_second_done", 64'(seen2), 64'd0);
      chk("result_kept", {data_hi, data_lo}, {mh, ml});
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          seen;

    reset_n    = 1'b0;
    start      = 1'b0;
    op         = 2'd0;
    src_a      = '0;
    src_b      = '0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    in_data_hi = '0;
    in_data_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(data_hi), 64'd0);
    chk("reset_lo", 64'(data_lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Direct writes while idle.
    write_hi   = 1'b1;
    write_lo   = 1'b1;
    in_data_hi = 32'h1234_5678;
    in_data_lo = 32'h9ABC_DEF0;
    @(negedge clk);
    write_hi = 1'b0;
    write_lo = 1'b0;
    chk("wr_hi", 64'(data_hi), 64'h1234_5678);
    chk("wr_lo", 64'(data_lo), 64'h9ABC_DEF0);
    @(negedge clk);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_hi", 64'(data_hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(data_lo), 64'h0000_0001);
    @(negedge clk);

    run_op(2'd0, -32'sd3, 32'd7, 1'b1, 1'b0);
    chk("mult_hi", 64'(data_hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(data_lo), 64'hFFFF_FFEB);

    run_op(2'd2, -32'sd7, 32'd2, 1'b0, 1'b0);
    chk("div_lo", 64'(data_lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(data_hi), 64'hFFFF_FFFF);

    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("divovf_lo", 64'(data_lo), 64'h8000_0000);
    chk("divovf_hi", 64'(data_hi), 64'd0);

    run_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
    chk("div0_lo", 64'(data_lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(data_hi), 64'h0000_0064);

    // Signed divide by zero keeps the raw dividend in HI.
    run_op(2'd2, -32'sd9, 32'd0, 1'b0, 1'b0);

    // Direct write during RUN must be ignored.
    run_op(2'd1, 32'd6, 32'd7, 1'b0, 1'b1);

    // Randomized back-to-back operations.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, 1'b0, 1'b0);
    end

    // Reset in the middle of RUN aborts with no done.
    @(negedge clk);
    start = 1'b1;
    op    = 2'd1;
    src_a = 32'd123;
    src_b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(data_hi), 64'd0);
    chk("midrst_lo", 64'(data_lo), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    seen    = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    chk("midrst_hilo_zero", {data_hi, data_lo}, 64'd0);

    run_op(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Parametrised HI/LO register pair with an attached iterative multiply/divide engine for the kanade32 execute stage. It stores HI/LO, accepts direct MTHI/MTLO-style writes, and runs MULT/MULTU/DIV/DIVU one bit per cycle. The 2·WIDTH-bit product or the quotient/remainder is committed to HI/LO on completion. `busy` drives the pipeline interlock for MFHI/MFLO and for further multiply/divide issue.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4.
- `clk` input 1: clock; all state updates on rising edge.
- `reset_n` input 1: reset, synchronous, active-low.
- `start` input 1: request an operation; sampled only in IDLE.
- `op` input 2: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `src_a` input WIDTH: multiplicand or dividend.
- `src_b` input WIDTH: multiplier or divisor.
- `write_hi` input 1: direct write of HI.
- `write_lo` input 1: direct write of LO.
- `in_data_hi` input WIDTH: direct-write data for HI.
- `in_data_lo` input WIDTH: direct-write data for LO.
- `busy` output 1: operation in flight (RUN or FIX).
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `data_hi` output WIDTH: HI contents.
- `data_lo` output WIDTH: LO contents.

## Operation
- FSM states: IDLE → RUN → FIX → IDLE.
- **IDLE:**
  - On `start`, latch `op`.
  - Latch operand magnitudes: two's-complement absolute value for MULT/DIV, raw for MULTU/DIVU.
  - Latch result-sign flags; clear the iteration counter; go to RUN.
- **RUN:** exactly WIDTH cycles, one iteration per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator, LSB of multiplier first.
  - Divide: restoring; shift the remainder left, subtract the divisor, set the quotient bit if non-negative, else restore.
  - After the WIDTH-th iteration, go to FIX.
- **FIX:**
  - Apply sign correction.
  - MULT: negate the 2·WIDTH product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write HI = product[2W-1:W] or remainder; LO = product[W-1:0] or quotient.
  - Go to IDLE and pulse `done`.
- **Divide by zero** (`src_b` == 0, DIV or DIVU): LO = all ones, HI = raw `src_a`. No sign correction. Latency is still the full WIDTH+1 cycles.
- **Signed overflow** (most-negative ÷ −1): LO = most-negative, HI = 0. This falls out of the magnitude arithmetic and is not special-cased.
- **Direct writes:**
  - Honoured only while `busy` is 0; ignored while `busy` is 1.
  - HI and LO are written independently; both may be written in the same cycle.
  - A direct write in the same cycle as an accepted `start` takes effect, then is overwritten at FIX.
- `start` while `busy` is ignored; there is no queuing.
- `op` and operands are don't-care outside the `start` cycle.

## Timing
- **Reset values:** `data_hi` = 0, `data_lo` = 0, `busy` = 0, `done` = 0, state IDLE.
- **Reset mid-operation:** abort, HI/LO return to 0, `busy` is 0 the next cycle, and no `done` pulse is produced.
- **Accept and busy window:** `start` is accepted at edge E0. `busy` is high for the cycles following edges E0 … E0+WIDTH+1 exclusive, i.e. WIDTH+1 cycles.
- **Commit:** HI/LO are updated at edge E0+WIDTH+1. `done` is high for the one cycle after that edge, while `busy` is 0.
- **Back-to-back:** a new `start` may be accepted in the same cycle `done` is high. The earliest issue interval is WIDTH+2 cycles.
- **Direct-write latency:** visible on `data_hi`/`data_lo` one cycle after the write edge.
- `data_hi`/`data_lo` are registered outputs and do not change during RUN.

## Structure
- Package `muldiv_pkg`:
  - `op` encoding constants (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`).
  - FSM state encoding constants.
- Sub-module `muldiv_iter_core` (WIDTH-parametrised) holds:
  - the accumulator and remainder/quotient shift registers;
  - the iteration counter;
  - the per-cycle add/subtract step.
- The top level holds the FSM, sign handling, HI/LO storage and the direct-write path.

## Test plan
All cases use WIDTH = 32.
- **MULTU:** `src_a` = `src_b` = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `done` exactly 33 edges after the `start` edge; `busy` high for 33 cycles.
- **MULT signed:** −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then `start` asserted during `busy` is ignored: no second `done`, result unchanged.
- **DIV signed:** −7 ÷ 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **DIV overflow:** 0x80000000 ÷ 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **DIVU by zero:** 100 ÷ 0 → LO = 0xFFFFFFFF, HI = 0x00000064, with full latency.
- **Direct writes and reset:**
  - In IDLE, `write_hi` with 0x12345678 and `write_lo` with 0x9ABCDEF0 → both visible next cycle.
  - During RUN, `write_hi` is ignored.
  - `reset_n` low mid-RUN → next cycle `busy` = 0, HI = LO = 0, no `done` pulse.
